// File: rtl/hazard_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_tracker_pkg
// Purpose : Shared constants for the pipeline hazard tracker: default widths,
//           link register, Tuse/Tnew values and forwarding select codes.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package hazard_tracker_pkg;

    // Default geometry
    localparam int DEF_REG_W    = 5;
    localparam int DEF_TNEW_W   = 2;
    localparam int DEF_LINK_REG = 31;

    // Tuse: cycles (counted from D) until a source operand is consumed
    localparam int TUSE_NOW   = 0;   // branch/jump compare in D
    localparam int TUSE_ALU   = 1;   // consumed by ALU in E
    localparam int TUSE_STORE = 2;   // store data consumed in M
    localparam int TUSE_NEVER = 3;   // operand not read

    // Tnew: cycles (counted from E) until a result is available
    localparam int TNEW_READY = 0;   // jal link value ready in E
    localparam int TNEW_ALU   = 1;   // ALU result ready at M
    localparam int TNEW_LOAD  = 2;   // load data ready at W

    // D-stage forward selects
    localparam logic [1:0] FWD_D_GRF    = 2'd0;
    localparam logic [1:0] FWD_D_FROM_E = 2'd1;
    localparam logic [1:0] FWD_D_FROM_M = 2'd2;

    // E-stage forward selects
    localparam logic [1:0] FWD_E_PIPE   = 2'd0;
    localparam logic [1:0] FWD_E_FROM_M = 2'd1;
    localparam logic [1:0] FWD_E_FROM_W = 2'd2;

    // M-stage forward selects
    localparam logic FWD_M_PIPE   = 1'b0;
    localparam logic FWD_M_FROM_W = 1'b1;

endpackage : hazard_tracker_pkg
`default_nettype wire

// File: rtl/hazard_tracker_classify.sv
`default_nettype none
// ============================================================================
// Module  : hazard_tracker_classify
// Purpose : Combinational decode of the D-stage instruction class into
//           operand use times, destination register and result latency.
// Ports   : i_is_*        one-hot instruction class bits (all zero = nop)
//           i_rs/i_rt/i_rd register fields
//           o_tuse_rs/rt  cycles until rs/rt are consumed (3 = never)
//           o_a3          destination register (0 = none)
//           o_tnew_e      cycles after E until the result exists
// Revision: 1.0  initial release
// ============================================================================
module hazard_tracker_classify
    import hazard_tracker_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int TNEW_W   = DEF_TNEW_W,
    parameter int LINK_REG = DEF_LINK_REG
) (
    input  logic              i_is_cali,
    input  logic              i_is_calr,
    input  logic              i_is_jal,
    input  logic              i_is_jr,
    input  logic              i_is_load,
    input  logic              i_is_store,
    input  logic              i_is_beq,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    output logic [TNEW_W-1:0] o_tuse_rs,
    output logic [TNEW_W-1:0] o_tuse_rt,
    output logic [REG_W-1:0]  o_a3,
    output logic [TNEW_W-1:0] o_tnew_e
);

    always_comb begin
        o_tuse_rs = TNEW_W'(TUSE_NEVER);
        if (i_is_jr || i_is_beq)
            o_tuse_rs = TNEW_W'(TUSE_NOW);
        else if (i_is_cali || i_is_calr || i_is_load || i_is_store)
            o_tuse_rs = TNEW_W'(TUSE_ALU);

        o_tuse_rt = TNEW_W'(TUSE_NEVER);
        if (i_is_beq)
            o_tuse_rt = TNEW_W'(TUSE_NOW);
        else if (i_is_calr)
            o_tuse_rt = TNEW_W'(TUSE_ALU);
        else if (i_is_store)
            o_tuse_rt = TNEW_W'(TUSE_STORE);

        o_a3 = '0;
        if (i_is_cali || i_is_load)
            o_a3 = i_rt;
        else if (i_is_calr)
            o_a3 = i_rd;
        else if (i_is_jal)
            o_a3 = REG_W'(LINK_REG);

        o_tnew_e = TNEW_W'(TNEW_READY);
        if (i_is_load)
            o_tnew_e = TNEW_W'(TNEW_LOAD);
        else if (i_is_cali || i_is_calr)
            o_tnew_e = TNEW_W'(TNEW_ALU);
    end

endmodule : hazard_tracker_classify
`default_nettype wire

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module  : hazard_tracker
// Purpose : Stall/forward controller for a 5-stage MIPS pipeline. Shadows the
//           E/M/W destination/latency state and produces a stall request and
//           forwarding selects for the D, E and M stages every cycle.
// Ports   : clk, reset             clock, synchronous active-high reset
//           D_is*                  one-hot D instruction class
//           D_rs, D_rt, D_rd       D register fields
//           stall                  hold F/D, insert bubble into E
//           fwd_D_rs/rt            0 GRF, 1 from E, 2 from M
//           fwd_E_rs/rt            0 pipe, 1 from M, 2 from W
//           fwd_M_rt               0 pipe, 1 from W
// Revision: 1.0  initial release
// ============================================================================
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int TNEW_W   = DEF_TNEW_W,
    parameter int LINK_REG = DEF_LINK_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_isCali,
    input  logic             D_isCalr,
    input  logic             D_isJal,
    input  logic             D_isJr,
    input  logic             D_isLoad,
    input  logic             D_isStore,
    input  logic             D_isBeq,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic [REG_W-1:0] D_rd,
    output logic             stall,
    output logic [1:0]       fwd_D_rs,
    output logic [1:0]       fwd_D_rt,
    output logic [1:0]       fwd_E_rs,
    output logic [1:0]       fwd_E_rt,
    output logic             fwd_M_rt
);

    // D-stage decode
    logic [TNEW_W-1:0] w_tuse_rs;
    logic [TNEW_W-1:0] w_tuse_rt;
    logic [REG_W-1:0]  w_d_a3;
    logic [TNEW_W-1:0] w_d_tnew;

    hazard_tracker_classify #(
        .REG_W    (REG_W),
        .TNEW_W   (TNEW_W),
        .LINK_REG (LINK_REG)
    ) u_classify (
        .i_is_cali  (D_isCali),
        .i_is_calr  (D_isCalr),
        .i_is_jal   (D_isJal),
        .i_is_jr    (D_isJr),
        .i_is_load  (D_isLoad),
        .i_is_store (D_isStore),
        .i_is_beq   (D_isBeq),
        .i_rs       (D_rs),
        .i_rt       (D_rt),
        .i_rd       (D_rd),
        .o_tuse_rs  (w_tuse_rs),
        .o_tuse_rt  (w_tuse_rt),
        .o_a3       (w_d_a3),
        .o_tnew_e   (w_d_tnew)
    );

    // Shadow pipeline state
    logic [REG_W-1:0]  e_rs_q,   e_rs_d;
    logic [REG_W-1:0]  e_rt_q,   e_rt_d;
    logic [REG_W-1:0]  e_a3_q,   e_a3_d;
    logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
    logic [REG_W-1:0]  m_rt_q,   m_rt_d;
    logic [REG_W-1:0]  m_a3_q,   m_a3_d;
    logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
    logic [REG_W-1:0]  wb_a3_q,  wb_a3_d;

    // Non-zero source qualifiers: $0 never participates in hazards
    logic w_d_rs_nz, w_d_rt_nz, w_e_rs_nz, w_e_rt_nz, w_m_rt_nz;

    assign w_d_rs_nz = |D_rs;
    assign w_d_rt_nz = |D_rt;
    assign w_e_rs_nz = |e_rs_q;
    assign w_e_rt_nz = |e_rt_q;
    assign w_m_rt_nz = |m_rt_q;

    // Stall when a producer in E or M cannot deliver before the consumer needs it
    always_comb begin
        stall = 1'b0;
        if (w_d_rs_nz && (D_rs == e_a3_q) && (w_tuse_rs < e_tnew_q)) stall = 1'b1;
        if (w_d_rs_nz && (D_rs == m_a3_q) && (w_tuse_rs < m_tnew_q)) stall = 1'b1;
        if (w_d_rt_nz && (D_rt == e_a3_q) && (w_tuse_rt < e_tnew_q)) stall = 1'b1;
        if (w_d_rt_nz && (D_rt == m_a3_q) && (w_tuse_rt < m_tnew_q)) stall = 1'b1;
    end

    // Forwarding selects; nearer stage wins when both match
    always_comb begin
        fwd_D_rs = FWD_D_GRF;
        if (w_d_rs_nz && (D_rs == e_a3_q) && (e_tnew_q == '0))
            fwd_D_rs = FWD_D_FROM_E;
        else if (w_d_rs_nz && (D_rs == m_a3_q) && (m_tnew_q == '0))
            fwd_D_rs = FWD_D_FROM_M;

        fwd_D_rt = FWD_D_GRF;
        if (w_d_rt_nz && (D_rt == e_a3_q) && (e_tnew_q == '0))
            fwd_D_rt = FWD_D_FROM_E;
        else if (w_d_rt_nz && (D_rt == m_a3_q) && (m_tnew_q == '0))
            fwd_D_rt = FWD_D_FROM_M;

        fwd_E_rs = FWD_E_PIPE;
        if (w_e_rs_nz && (e_rs_q == m_a3_q) && (m_tnew_q == '0))
            fwd_E_rs = FWD_E_FROM_M;
        else if (w_e_rs_nz && (e_rs_q == wb_a3_q))
            fwd_E_rs = FWD_E_FROM_W;

        fwd_E_rt = FWD_E_PIPE;
        if (w_e_rt_nz && (e_rt_q == m_a3_q) && (m_tnew_q == '0))
            fwd_E_rt = FWD_E_FROM_M;
        else if (w_e_rt_nz && (e_rt_q == wb_a3_q))
            fwd_E_rt = FWD_E_FROM_W;

        fwd_M_rt = FWD_M_PIPE;
        if (w_m_rt_nz && (m_rt_q == wb_a3_q))
            fwd_M_rt = FWD_M_FROM_W;
    end

    // Next shadow state: a stall injects an all-zero bubble into E
    always_comb begin
        e_rs_d   = stall ? '0 : D_rs;
        e_rt_d   = stall ? '0 : D_rt;
        e_a3_d   = stall ? '0 : w_d_a3;
        e_tnew_d = stall ? '0 : w_d_tnew;
        m_rt_d   = e_rt_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - 1'b1;
        wb_a3_d  = m_a3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            m_rt_q   <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            wb_a3_q  <= '0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            m_rt_q   <= m_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            wb_a3_q  <= wb_a3_d;
        end
    end

endmodule : hazard_tracker
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_tracker
// Purpose : Self-checking bench for hazard_tracker: directed pipeline
//           scenarios followed by random instruction streams, compared each
//           cycle against an age-based reference model of in-flight writers.
// Revision: 1.0  initial release
// ============================================================================
module tb_hazard_tracker;

    localparam int C_NOP = 0, C_CALI = 1, C_CALR = 2, C_JAL = 3,
                   C_JR = 4, C_LOAD = 5, C_STORE = 6, C_BEQ = 7;

    typedef struct {
        int         cls;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    // One in-flight instruction; index in pipe[] is its age past D (0=E,1=M,2=W)
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        int         lat;   // result latency measured from E
    } slot_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       D_isCali, D_isCalr, D_isJal, D_isJr, D_isLoad, D_isStore, D_isBeq;
    logic [4:0] D_rs, D_rt, D_rd;
    logic       stall;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic       fwd_M_rt;

    hazard_tracker dut (
        .clk       (clk),
        .reset     (reset),
        .D_isCali  (D_isCali),
        .D_isCalr  (D_isCalr),
        .D_isJal   (D_isJal),
        .D_isJr    (D_isJr),
        .D_isLoad  (D_isLoad),
        .D_isStore (D_isStore),
        .D_isBeq   (D_isBeq),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_rd      (D_rd),
        .stall     (stall),
        .fwd_D_rs  (fwd_D_rs),
        .fwd_D_rt  (fwd_D_rt),
        .fwd_E_rs  (fwd_E_rs),
        .fwd_E_rt  (fwd_E_rt),
        .fwd_M_rt  (fwd_M_rt)
    );

    always #5 clk = ~clk;

    int    n_pass  = 0;
    int    n_total = 0;
    slot_t pipe [3];
    bit    m_stall_now;
    instr_t cur;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int use_rs(instr_t i);
        case (i.cls)
            C_JR, C_BEQ:                     return 0;
            C_CALI, C_CALR, C_LOAD, C_STORE: return 1;
            default:                         return 3;
        endcase
    endfunction

    function automatic int use_rt(instr_t i);
        case (i.cls)
            C_BEQ:   return 0;
            C_CALR:  return 1;
            C_STORE: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic slot_t issue(instr_t i);
        slot_t s;
        s.rs = i.rs;
        s.rt = i.rt;
        case (i.cls)
            C_CALI:  begin s.a3 = i.rt;  s.lat = 1; end
            C_LOAD:  begin s.a3 = i.rt;  s.lat = 2; end
            C_CALR:  begin s.a3 = i.rd;  s.lat = 1; end
            C_JAL:   begin s.a3 = 5'd31; s.lat = 0; end
            default: begin s.a3 = 5'd0;  s.lat = 0; end
        endcase
        return s;
    endfunction

    function automatic slot_t bubble();
        slot_t s;
        s.rs = 0; s.rt = 0; s.a3 = 0; s.lat = 0;
        return s;
    endfunction

    // Cycles still needed by the writer at age k
    function automatic int remaining(int k);
        int r;
        r = pipe[k].lat - k;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit exp_stall(instr_t i);
        bit s = 0;
        for (int k = 0; k < 2; k++) begin
            if (i.rs != 0 && i.rs == pipe[k].a3 && use_rs(i) < remaining(k)) s = 1;
            if (i.rt != 0 && i.rt == pipe[k].a3 && use_rt(i) < remaining(k)) s = 1;
        end
        return s;
    endfunction

    // Youngest ready writer among ages [lo..hi]; result code = age+1-lo+base
    function automatic int exp_fwd(logic [4:0] src, int lo, int hi, bit need_ready);
        for (int k = lo; k <= hi; k++)
            if (src != 0 && src == pipe[k].a3 && (!need_ready || remaining(k) == 0 || k == 2))
                return k - lo + 1;
        return 0;
    endfunction

    task automatic drive(input instr_t i);
        D_isCali  = (i.cls == C_CALI);
        D_isCalr  = (i.cls == C_CALR);
        D_isJal   = (i.cls == C_JAL);
        D_isJr    = (i.cls == C_JR);
        D_isLoad  = (i.cls == C_LOAD);
        D_isStore = (i.cls == C_STORE);
        D_isBeq   = (i.cls == C_BEQ);
        D_rs = i.rs; D_rt = i.rt; D_rd = i.rd;
    endtask

    // Drive D, wait to the middle of the cycle and compare all outputs
    task automatic settle(input instr_t i);
        cur = i;
        drive(i);
        @(negedge clk);
        m_stall_now = exp_stall(i);
        chk("stall",    {3'b0, stall},    {3'b0, m_stall_now});
        chk("fwd_D_rs", {2'b0, fwd_D_rs}, 4'(exp_fwd(i.rs, 0, 1, 1)));
        chk("fwd_D_rt", {2'b0, fwd_D_rt}, 4'(exp_fwd(i.rt, 0, 1, 1)));
        chk("fwd_E_rs", {2'b0, fwd_E_rs}, 4'(exp_fwd(pipe[0].rs, 1, 2, 1)));
        chk("fwd_E_rt", {2'b0, fwd_E_rt}, 4'(exp_fwd(pipe[0].rt, 1, 2, 1)));
        chk("fwd_M_rt", {3'b0, fwd_M_rt},
            {3'b0, (pipe[1].rt != 0 && pipe[1].rt == pipe[2].a3)});
    endtask

    task automatic advance();
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = m_stall_now ? bubble() : issue(cur);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) pipe[k] = bubble();
        #1;
        reset = 1'b0;
    endtask

    function automatic instr_t mk(int cls, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        instr_t i;
        i.cls = cls; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    instr_t nop, rnd;

    initial begin
        nop = mk(C_NOP, 0, 0, 0);
        drive(nop);
        do_reset();

        // Reset state
        settle(nop);
        chk("rst_stall", {3'b0, stall}, 4'd0);
        chk("rst_fwd_M", {3'b0, fwd_M_rt}, 4'd0);
        advance();

        // lw $1 ; addu $2,$1,$3 : one stall, then W forward in E
        do_reset();
        settle(mk(C_LOAD, 0, 1, 0));               advance();
        settle(mk(C_CALR, 1, 3, 2));  chk("lw_addu_st1", {3'b0, stall}, 4'd1); advance();
        settle(mk(C_CALR, 1, 3, 2));  chk("lw_addu_st2", {3'b0, stall}, 4'd0); advance();
        settle(nop);                  chk("lw_addu_fwdE", {2'b0, fwd_E_rs}, 4'd2); advance();

        // lw $1 ; beq $1,$0 : two stalls, then register file
        do_reset();
        settle(mk(C_LOAD, 0, 1, 0));               advance();
        settle(mk(C_BEQ, 1, 0, 0));   chk("lw_beq_st1", {3'b0, stall}, 4'd1); advance();
        settle(mk(C_BEQ, 1, 0, 0));   chk("lw_beq_st2", {3'b0, stall}, 4'd1); advance();
        settle(mk(C_BEQ, 1, 0, 0));   chk("lw_beq_st3", {3'b0, stall}, 4'd0);
                                      chk("lw_beq_fwdD", {2'b0, fwd_D_rs}, 4'd0); advance();

        // ori $5 ; sw $5,0($6) : M then W forwarding chain
        do_reset();
        settle(mk(C_CALI, 0, 5, 0));               advance();
        settle(mk(C_STORE, 6, 5, 0)); chk("ori_sw_st", {3'b0, stall}, 4'd0); advance();
        settle(nop);                  chk("ori_sw_fwdE", {2'b0, fwd_E_rt}, 4'd1); advance();
        settle(nop);                  chk("ori_sw_fwdM", {3'b0, fwd_M_rt}, 4'd1); advance();

        // jal ; jr $31 : E forward, no stall
        do_reset();
        settle(mk(C_JAL, 0, 0, 0));                advance();
        settle(mk(C_JR, 31, 0, 0));   chk("jal_jr_st", {3'b0, stall}, 4'd0);
                                      chk("jal_jr_fwdD", {2'b0, fwd_D_rs}, 4'd1); advance();

        // addu $0 ; beq $0,$0 : register zero never matches
        do_reset();
        settle(mk(C_CALR, 1, 2, 0));               advance();
        settle(mk(C_BEQ, 0, 0, 0));   chk("r0_st", {3'b0, stall}, 4'd0);
                                      chk("r0_fwdD_rs", {2'b0, fwd_D_rs}, 4'd0);
                                      chk("r0_fwdD_rt", {2'b0, fwd_D_rt}, 4'd0); advance();

        // Reset mid-stream with lw in E
        do_reset();
        settle(mk(C_LOAD, 0, 1, 0));               advance();
        drive(mk(C_CALR, 1, 1, 2));
        reset = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) pipe[k] = bubble();
        #1;
        reset = 1'b0;
        settle(mk(C_CALR, 1, 1, 2));
        chk("rstmid_st",   {3'b0, stall},    4'd0);
        chk("rstmid_fDrs", {2'b0, fwd_D_rs}, 4'd0);
        chk("rstmid_fErs", {2'b0, fwd_E_rs}, 4'd0);
        chk("rstmid_fM",   {3'b0, fwd_M_rt}, 4'd0);
        advance();

        // Random instruction stream; D is held while the model predicts a stall
        do_reset();
        rnd = nop;
        for (int n = 0; n < 600; n++) begin
            if (!m_stall_now)
                rnd = mk($urandom_range(0, 7), rreg(), rreg(), rreg());
            settle(rnd);
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hazard_tracker
`default_nettype wire
